// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI state encoding, default modes and clog2 helper
package spi_pkg;

  typedef logic [2:0] spi_state_t;

  // Word-engine FSM encoding, kept as plain 3-bit constants for older tools
  localparam spi_state_t ST_IDLE  = 3'd0;
  localparam spi_state_t ST_SETUP = 3'd1;
  localparam spi_state_t ST_XFER  = 3'd2;
  localparam spi_state_t ST_HOLD  = 3'd3;
  localparam spi_state_t ST_DONE  = 3'd4;

  // Default bus mode shared with the SCLK generator and edge detector
  localparam bit DEF_CPOL = 1'b0;
  localparam bit DEF_CPHA = 1'b1;

  // Smallest r such that 2**r >= value
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// rtl/spi_shift_reg.sv - parallel-load transmit shifter and serial-in receive shifter
module spi_shift_reg
  import spi_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic              i_shift,
  input  logic              i_sample,
  input  logic              i_sin,
  output logic              o_sout,
  output logic [DATA_W-1:0] o_rx_word
);

  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] r_rx;

  // Transmit register: load a new word, then move the next bit to the active end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tx <= '0;
    end else if (i_load) begin
      r_tx <= i_load_data;
    end else if (i_shift) begin
      if (MSB_FIRST) begin
        r_tx <= {r_tx[DATA_W-2:0], 1'b0};
      end else begin
        r_tx <= {1'b0, r_tx[DATA_W-1:1]};
      end
    end
  end

  // Receive register: cleared on load so a word never mixes with the previous one
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rx <= '0;
    end else if (i_load) begin
      r_rx <= '0;
    end else if (i_sample) begin
      if (MSB_FIRST) begin
        r_rx <= {r_rx[DATA_W-2:0], i_sin};
      end else begin
        r_rx <= {i_sin, r_rx[DATA_W-1:1]};
      end
    end
  end

  assign o_sout    = MSB_FIRST ? r_tx[DATA_W-1] : r_tx[0];
  assign o_rx_word = r_rx;

endmodule

// File: rtl/spi_xfer_ctrl.sv
// rtl/spi_xfer_ctrl.sv - SPI master word engine: chip select timing, bit counting, host handshake
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit CPHA      = DEF_CPHA,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CS_SETUP  = 2,
  parameter int CS_HOLD   = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_sampl_en,
  input  logic              i_shift_en,
  input  logic              i_miso,
  output logic              o_mosi,
  output logic              o_cs_n,
  output logic              o_sclk_run,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_rx_data
);

  localparam int BCW     = clog2(DATA_W + 1);
  localparam int CNT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CW      = clog2(CNT_MAX + 1);

  localparam logic [BCW-1:0] BIT_LAST   = BCW'(DATA_W - 1);
  localparam logic [CW-1:0]  SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0]  HOLD_LAST  = CW'(CS_HOLD - 1);

  spi_state_t        r_state;
  logic [BCW-1:0]    r_bit_cnt;
  logic [CW-1:0]     r_cnt;
  logic              r_first_shift;
  logic              r_cs_n;
  logic              r_sclk_run;
  logic              r_busy;
  logic              r_done;
  logic [DATA_W-1:0] r_rx_data;

  logic              w_in_xfer;
  logic              w_load;
  logic              w_sample;
  logic              w_shift;
  logic              w_sout;
  logic [DATA_W-1:0] w_rx_word;

  assign w_in_xfer = (r_state == ST_XFER);
  assign w_load    = (r_state == ST_IDLE) && i_start;
  assign w_sample  = w_in_xfer && i_sampl_en;
  // With CPHA=1 the first bit is already on the wire, so the first shift strobe only arms shifting
  assign w_shift   = w_in_xfer && i_shift_en && ((CPHA == 1'b0) || r_first_shift);

  spi_shift_reg #(
    .DATA_W    (DATA_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_reg (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load      (w_load),
    .i_load_data (i_tx_data),
    .i_shift     (w_shift),
    .i_sample    (w_sample),
    .i_sin       (i_miso),
    .o_sout      (w_sout),
    .o_rx_word   (w_rx_word)
  );

  // Transfer sequencer: chip-select setup, bit collection, chip-select hold, completion pulse
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_bit_cnt     <= '0;
      r_cnt         <= '0;
      r_first_shift <= 1'b0;
      r_cs_n        <= 1'b1;
      r_sclk_run    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_rx_data     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_bit_cnt     <= '0;
            r_first_shift <= 1'b0;
            r_cnt         <= '0;
            r_cs_n        <= 1'b0;
            r_busy        <= 1'b1;
            r_state       <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (r_cnt == SETUP_LAST) begin
            r_cnt      <= '0;
            r_sclk_run <= 1'b1;
            r_state    <= ST_XFER;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_XFER: begin
          if (i_shift_en) begin
            r_first_shift <= 1'b1;
          end
          if (i_sampl_en) begin
            r_bit_cnt <= r_bit_cnt + BCW'(1);
            if (r_bit_cnt == BIT_LAST) begin
              r_sclk_run <= 1'b0;
              r_state    <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            r_cs_n  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_DONE: begin
          r_rx_data <= w_rx_word;
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_mosi     = r_cs_n ? 1'b0 : w_sout;
  assign o_cs_n     = r_cs_n;
  assign o_sclk_run = r_sclk_run;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_rx_data  = r_rx_data;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb/tb_spi_xfer_ctrl.sv - directed bench for three spi_xfer_ctrl variants driven in lockstep
module tb_spi_xfer_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start;
  logic [7:0] tx_a, tx_b, tx_c;
  logic       sampl, sh1, sh0, miso_b;

  logic       mosi_a, cs_a, run_a, busy_a, done_a;
  logic       mosi_b, cs_b, run_b, busy_b, done_b;
  logic       mosi_c, cs_c, run_c, busy_c, done_c;
  logic [7:0] rx_a, rx_b, rx_c;

  int total = 0;
  int bad = 0;
  int n_done = 0;
  int words_done = 0;

  // a: CPHA=1 MSB first, loopback
  spi_xfer_ctrl #(.DATA_W(8), .CPHA(1'b1), .MSB_FIRST(1'b1), .CS_SETUP(2), .CS_HOLD(2)) u_a (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_tx_data(tx_a),
    .i_sampl_en(sampl), .i_shift_en(sh1), .i_miso(mosi_a),
    .o_mosi(mosi_a), .o_cs_n(cs_a), .o_sclk_run(run_a), .o_busy(busy_a),
    .o_done(done_a), .o_rx_data(rx_a));

  // b: CPHA=0 MSB first, miso driven by the bench
  spi_xfer_ctrl #(.DATA_W(8), .CPHA(1'b0), .MSB_FIRST(1'b1), .CS_SETUP(2), .CS_HOLD(2)) u_b (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_tx_data(tx_b),
    .i_sampl_en(sampl), .i_shift_en(sh0), .i_miso(miso_b),
    .o_mosi(mosi_b), .o_cs_n(cs_b), .o_sclk_run(run_b), .o_busy(busy_b),
    .o_done(done_b), .o_rx_data(rx_b));

  // c: CPHA=1 LSB first, loopback
  spi_xfer_ctrl #(.DATA_W(8), .CPHA(1'b1), .MSB_FIRST(1'b0), .CS_SETUP(2), .CS_HOLD(2)) u_c (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_tx_data(tx_c),
    .i_sampl_en(sampl), .i_shift_en(sh1), .i_miso(mosi_c),
    .o_mosi(mosi_c), .o_cs_n(cs_c), .o_sclk_run(run_c), .o_busy(busy_c),
    .o_done(done_c), .o_rx_data(rx_c));

  always @(posedge clk) begin
    if (done_a) n_done <= n_done + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_word(input logic [7:0] ta, input logic [7:0] tb, input logic [7:0] tc,
                         input logic [7:0] mb, input bit coinc, input bit spur,
                         input bit start_mid, input bit chain_out, input int abort_n);
    tx_a = ta; tx_b = tb; tx_c = tc; start = 1'b1;
    step();
    start = 1'b0; tx_a = ~ta; tx_b = ~tb; tx_c = ~tc;
    chk("acc_cs_n_a", 32'(cs_a), 0);
    chk("acc_cs_n_b", 32'(cs_b), 0);
    chk("acc_busy", 32'(busy_a), 1);
    chk("acc_run", 32'(run_a), 0);
    chk("done_count", 32'(n_done), 32'(words_done));
    step();
    chk("setup_run", 32'(run_a), 0);
    step();
    chk("run_a", 32'(run_a), 1);
    chk("run_b", 32'(run_b), 1);
    for (int i = 0; i < 8; i++) begin
      sh1 = coinc ? (i == 0) : 1'b1;
      sh0 = coinc ? 1'b0 : (i > 0);
      step();
      sh1 = 1'b0; sh0 = 1'b0;
      if (start_mid && i == 3) start = 1'b1;
      step();
      start = 1'b0;
      sampl = 1'b1;
      miso_b = mb[7-i];
      if (coinc && i < 7) begin
        sh1 = 1'b1; sh0 = 1'b1;
      end
      chk("mosi_a", 32'(mosi_a), 32'(ta[7-i]));
      chk("mosi_b", 32'(mosi_b), 32'(tb[7-i]));
      chk("mosi_c", 32'(mosi_c), 32'(tc[i]));
      step();
      sampl = 1'b0; sh1 = 1'b0; sh0 = 1'b0;
      if (abort_n == i + 1) begin
        #2 rst = 1'b1;
        #1;
        chk("rst_cs_n", 32'(cs_a), 1);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_run", 32'(run_a), 0);
        chk("rst_mosi", 32'(mosi_a), 0);
        chk("rst_rx", 32'(rx_a), 0);
        chk("rst_cs_n_b", 32'(cs_b), 1);
        step();
        rst = 1'b0;
        step();
        return;
      end
      if (i < 7) step();
    end
    chk("last_run_a", 32'(run_a), 0);
    chk("last_run_b", 32'(run_b), 0);
    chk("last_cs", 32'(cs_a), 0);
    chk("last_busy", 32'(busy_a), 1);
    if (spur) begin
      sampl = 1'b1; sh1 = 1'b1; sh0 = 1'b1; miso_b = ~mb[0];
    end
    step();
    sampl = 1'b0; sh1 = 1'b0; sh0 = 1'b0;
    chk("hold_cs", 32'(cs_a), 0);
    chk("hold_mosi", 32'(mosi_a), 32'(ta[0]));
    chk("hold_done", 32'(done_a), 0);
    step();
    chk("hold_end_cs", 32'(cs_a), 1);
    chk("hold_end_done", 32'(done_a), 0);
    chk("mosi_off", 32'(mosi_a), 0);
    step();
    chk("done_a", 32'(done_a), 1);
    chk("done_b", 32'(done_b), 1);
    chk("done_c", 32'(done_c), 1);
    chk("busy_end", 32'(busy_a), 0);
    chk("rx_a", 32'(rx_a), 32'(ta));
    chk("rx_b", 32'(rx_b), 32'(mb));
    chk("rx_c", 32'(rx_c), 32'(tc));
    words_done++;
    if (!chain_out) begin
      step();
      chk("done_pulse", 32'(done_a), 0);
      chk("rx_stable", 32'(rx_a), 32'(ta));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    tx_a = 8'h00; tx_b = 8'h00; tx_c = 8'h00;
    sampl = 1'b0; sh1 = 1'b0; sh0 = 1'b0; miso_b = 1'b0;
    step();
    step();
    chk("reset_cs_n", 32'(cs_a), 1);
    chk("reset_mosi", 32'(mosi_a), 0);
    chk("reset_run", 32'(run_a), 0);
    chk("reset_busy", 32'(busy_a), 0);
    chk("reset_done", 32'(done_a), 0);
    chk("reset_rx", 32'(rx_a), 0);
    chk("reset_cs_n_b", 32'(cs_b), 1);
    chk("reset_cs_n_c", 32'(cs_c), 1);
    rst = 1'b0;
    step();

    do_word(8'hA5, 8'h3C, 8'h01, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    sampl = 1'b1; sh1 = 1'b1; sh0 = 1'b1; miso_b = 1'b1;
    step();
    step();
    sampl = 1'b0; sh1 = 1'b0; sh0 = 1'b0;
    step();
    chk("idle_cs_n", 32'(cs_a), 1);
    chk("idle_busy", 32'(busy_a), 0);
    chk("idle_done", 32'(done_a), 0);
    chk("idle_rx", 32'(rx_a), 32'h A5);

    do_word(8'h5A, 8'h81, 8'h80, 8'h96, 1'b1, 1'b1, 1'b1, 1'b1, 0);
    do_word(8'h0F, 8'hF0, 8'h7E, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    do_word(8'hFF, 8'h55, 8'hAA, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 4);
    do_word(8'h96, 8'h69, 8'hC3, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    step();
    chk("final_done_count", 32'(n_done), 4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
